// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchroniser plus per-bit counter debounce for board switches.
// Ports: t_clk/t_rst (async active-high), t_sw_raw raw switches, t_irq_ack flag clear,
//        o_sw debounced vector, o_chg_mask/o_chg one-cycle change pulses, o_sw_irq sticky flag.
// Optional feature: define SW_DEBOUNCE_IRQ_EN to build the sticky o_sw_irq flag; otherwise it is tied 0.
// Latency: DEBOUNCE_CYCLES+2 edges from first raw sample to o_sw update. All outputs registered.

module sw_debounce #(
  parameter int               WIDTH           = 8,
  parameter int               DEBOUNCE_CYCLES = 5,
  parameter logic [WIDTH-1:0] RESET_VAL       = {WIDTH{1'b0}}
) (
  input  logic             t_clk,
  input  logic             t_rst,
  input  logic [WIDTH-1:0] t_sw_raw,
  input  logic             t_irq_ack,
  output logic [WIDTH-1:0] o_sw,
  output logic [WIDTH-1:0] o_chg_mask,
  output logic             o_chg,
  output logic             o_sw_irq
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [CW-1:0]    r_cnt      [WIDTH];
  logic [CW-1:0]    w_cnt_nxt  [WIDTH];
  logic [WIDTH-1:0] w_sw_nxt;
  logic [WIDTH-1:0] w_mask_nxt;

  // A bit only counts while the synchronised level disagrees with the
  // accepted level; any agreement (end of a glitch) restarts the count.
  // The counter tops out at DEBOUNCE_CYCLES-1, where the new level is taken.
  always_comb begin
    w_sw_nxt   = o_sw;
    w_mask_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_s2[i] != o_sw[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_sw_nxt[i]   = r_s2[i];
          w_mask_nxt[i] = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge t_clk or posedge t_rst) begin
    if (t_rst) begin
      r_s1       <= RESET_VAL;
      r_s2       <= RESET_VAL;
      o_sw       <= RESET_VAL;
      o_chg_mask <= '0;
      o_chg      <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1       <= t_sw_raw;
      r_s2       <= r_s1;
      o_sw       <= w_sw_nxt;
      o_chg_mask <= w_mask_nxt;
      o_chg      <= |w_mask_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

`ifdef SW_DEBOUNCE_IRQ_EN
  logic r_irq;

  // Set has priority over acknowledge so a change landing on the ack edge is not lost.
  always_ff @(posedge t_clk or posedge t_rst) begin
    if (t_rst) begin
      r_irq <= 1'b0;
    end else if (o_chg) begin
      r_irq <= 1'b1;
    end else if (t_irq_ack) begin
      r_irq <= 1'b0;
    end
  end

  assign o_sw_irq = r_irq;
`else
  logic w_unused_ack;
  assign w_unused_ack = t_irq_ack;
  assign o_sw_irq     = 1'b0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
module tb_sw_debounce;

  logic       t_clk;
  logic       t_rst;
  logic [7:0] t_sw_raw;
  logic       t_irq_ack;
  logic [7:0] o_sw;
  logic [7:0] o_chg_mask;
  logic       o_chg;
  logic       o_sw_irq;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic [7:0] sw;
    logic [7:0] mask;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] exp_sw = 8'h00;

  sw_debounce #(
    .WIDTH(8),
    .DEBOUNCE_CYCLES(5),
    .RESET_VAL(8'h00)
  ) dut (
    .t_clk(t_clk),
    .t_rst(t_rst),
    .t_sw_raw(t_sw_raw),
    .t_irq_ack(t_irq_ack),
    .o_sw(o_sw),
    .o_chg_mask(o_chg_mask),
    .o_chg(o_chg),
    .o_sw_irq(o_sw_irq)
  );

  initial begin
    t_clk = 1'b0;
    forever #10 t_clk = ~t_clk;
  end

  always @(posedge t_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  // Called at a falling edge: the raw change is first sampled on the next
  // rising edge (E), so the accepted update is visible after edge E+6.
  task automatic drive_change(input logic [7:0] raw, input logic [7:0] sw, input logic [7:0] mask);
    exp_t e;
    t_sw_raw = raw;
    e.cyc  = cyc + 7;
    e.sw   = sw;
    e.mask = mask;
    sb.push_back(e);
  endtask

  // Monitor: samples 1 ns after each rising edge, pops an expectation for every pulse.
  always begin
    exp_t e;
    @(posedge t_clk);
    #1;
    if (t_rst) begin
      exp_sw = 8'h00;
    end else if (o_chg || (o_chg_mask != 8'h00)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse at cycle %0d: got mask %h expected no pulse", cyc, o_chg_mask);
      end else begin
        e = sb.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_mask", {24'd0, o_chg_mask}, {24'd0, e.mask});
        exp_sw = e.sw;
      end
    end
    chk("o_sw_track", {24'd0, o_sw}, {24'd0, exp_sw});
    chk("o_chg_vs_mask", {31'd0, o_chg}, {31'd0, |o_chg_mask});
`ifndef SW_DEBOUNCE_IRQ_EN
    chk("irq_tied_low", {31'd0, o_sw_irq}, 32'd0);
`endif
  end

  initial begin
    t_rst     = 1'b1;
    t_sw_raw  = 8'h00;
    t_irq_ack = 1'b0;
    #1;
    chk("rst_o_sw", {24'd0, o_sw}, 32'd0);
    chk("rst_mask", {24'd0, o_chg_mask}, 32'd0);
    chk("rst_chg", {31'd0, o_chg}, 32'd0);
    chk("rst_irq", {31'd0, o_sw_irq}, 32'd0);
    repeat (5) @(negedge t_clk);   // 100 ns of reset
    t_rst = 1'b0;

    // Step to 8'h25
    repeat (2) @(negedge t_clk);
    drive_change(8'h25, 8'h25, 8'h25);
    repeat (10) @(negedge t_clk);
`ifdef SW_DEBOUNCE_IRQ_EN
    chk("irq_set_after_step", {31'd0, o_sw_irq}, 32'd1);
    t_irq_ack = 1'b1;
    @(negedge t_clk);
    t_irq_ack = 1'b0;
    chk("irq_cleared_by_ack", {31'd0, o_sw_irq}, 32'd0);
`endif

    // All bits flip at once; ack lands on the edge that sets the flag.
    @(negedge t_clk);
    drive_change(8'hDA, 8'hDA, 8'hFF);
    repeat (7) @(negedge t_clk);
    t_irq_ack = 1'b1;
    @(negedge t_clk);
    t_irq_ack = 1'b0;
    @(negedge t_clk);
`ifdef SW_DEBOUNCE_IRQ_EN
    chk("irq_set_wins_over_ack", {31'd0, o_sw_irq}, 32'd1);
`endif
    repeat (3) @(negedge t_clk);

    // Return to zero through reset
    t_sw_raw = 8'h00;
    t_rst    = 1'b1;
    #1;
    chk("rst_async_o_sw", {24'd0, o_sw}, 32'd0);
    chk("rst_async_irq", {31'd0, o_sw_irq}, 32'd0);
    repeat (2) @(negedge t_clk);
    t_rst = 1'b0;
    repeat (10) @(negedge t_clk);

    // Bounce on bit 0: 4-cycle highs separated by 1-cycle lows
    for (int r = 0; r < 5; r++) begin
      t_sw_raw = 8'h01;
      repeat (4) @(negedge t_clk);
      t_sw_raw = 8'h00;
      @(negedge t_clk);
    end
    chk("bounce_no_update", {24'd0, o_sw}, 32'd0);
    drive_change(8'h01, 8'h01, 8'h01);
    repeat (10) @(negedge t_clk);

    // Reset three cycles into a change toward 8'h80
    t_sw_raw = 8'h80;
    repeat (3) @(negedge t_clk);
    #5;
    t_rst = 1'b1;
    #1;
    chk("midcount_rst_o_sw", {24'd0, o_sw}, 32'd0);
    chk("midcount_rst_mask", {24'd0, o_chg_mask}, 32'd0);
    chk("midcount_rst_chg", {31'd0, o_chg}, 32'd0);
    repeat (2) @(negedge t_clk);
    t_rst = 1'b0;
    drive_change(8'h80, 8'h80, 8'h80);

    // Drain with a bounded wait
    for (int k = 0; k < 30 && sb.size() != 0; k++) @(negedge t_clk);
    repeat (3) @(negedge t_clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    chk("final_o_sw", {24'd0, o_sw}, 32'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Input-conditioning stage directly upstream of the processor's switch port: takes the raw board switches, synchronises them into the processor clock domain, filters contact bounce per bit, and drives the stable switch vector the processor samples. It also reports which bits changed, as a one-cycle mask pulse plus an optional sticky change flag. The processor consumes it through its 8-bit switch input; the debounced vector connects where the raw switches connected before.

## Interface
Parameters:
- WIDTH, 8, number of switch bits
- DEBOUNCE_CYCLES, 5, consecutive synchronised cycles a new level must hold before it is accepted; legal range 1..65535
- RESET_VAL, {WIDTH{1'b0}}, value of the synchronisers and of o_sw during and after reset

Ports:
- t_clk, input, 1, processor clock; all state updates on the rising edge
- t_rst, input, 1, reset, asynchronous and active-high
- t_sw_raw, input, WIDTH, raw asynchronous switch levels from the board
- t_irq_ack, input, 1, clears o_sw_irq; honoured only when SW_DEBOUNCE_IRQ_EN is defined
- o_sw, output, WIDTH, debounced, registered switch vector to the processor
- o_chg_mask, output, WIDTH, one-cycle pulse; bit i is 1 in the cycle o_sw[i] toggles
- o_chg, output, 1, OR-reduction of o_chg_mask, registered in the same cycle
- o_sw_irq, output, 1, sticky "some bit changed" flag; constant 0 when the feature is compiled out

## Operation
- Synchroniser: two flops per bit, s1 <= t_sw_raw and s2 <= s1. No logic sits between the stages.
- Per-bit counter cnt[i] is $clog2(DEBOUNCE_CYCLES+1) bits wide. Every bit has its own independent counter.
- Per bit, on each edge, exactly one of these applies:
  - If s2[i] == o_sw[i]: cnt[i] <= 0.
  - If s2[i] != o_sw[i] and cnt[i] == DEBOUNCE_CYCLES-1: o_sw[i] <= s2[i], cnt[i] <= 0, o_chg_mask[i] <= 1.
  - Otherwise: cnt[i] <= cnt[i]+1.
- o_chg_mask bits that are not updating are written 0 every cycle. A pulse therefore lasts exactly one cycle.
- A glitch at s2 shorter than DEBOUNCE_CYCLES cycles resets the counter when it ends. o_sw does not move and no pulse is produced.
- When several bits qualify on the same edge, they all update together. o_chg_mask shows every one of them and o_chg pulses once.
- The counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Reset (asserted at any time, including mid-count):
  - s1, s2 and o_sw go to RESET_VAL.
  - All counters, o_chg_mask, o_chg and o_sw_irq go to 0.
  - Reset takes effect immediately, without waiting for a clock edge. Nothing is in flight after it deasserts.
- After reset deasserts, a t_sw_raw that differs from RESET_VAL is treated as an ordinary change and is debounced normally.

## Timing
- The raw level is first sampled at edge E. s2 holds the new level after E+1.
- The mismatch is counted at edges E+2 .. E+1+DEBOUNCE_CYCLES.
- o_sw and o_chg_mask/o_chg update at edge E+1+DEBOUNCE_CYCLES. Total latency is DEBOUNCE_CYCLES+2 edges, counting edge E (7 edges by default).
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- Macro: SW_DEBOUNCE_IRQ_EN.
- Defined:
  - o_sw_irq <= 1 on any edge where o_chg is 1.
  - It is cleared on an edge where t_irq_ack == 1 and o_chg == 0.
  - If the set and the ack happen on the same edge, the set wins and the flag stays 1.
- Undefined:
  - o_sw_irq is tied to 0.
  - t_irq_ack is ignored.
  - No flag register is synthesised.

## Test plan
All scenarios use WIDTH=8, DEBOUNCE_CYCLES=5, RESET_VAL=0, and a 20 ns clock.
- Reset then step: hold t_rst high for 100 ns, release it, then drive t_sw_raw=8'h25 at a stable level. Required: o_sw stays 8'h00 until the 7th edge after sampling. It then becomes 8'h25 with a single one-cycle o_chg_mask=8'h25 and o_chg=1.
- Bounce: toggle bit 0 with high pulses of 4 cycles separated by 1-cycle lows, 5 repetitions, then hold it high. Required: o_sw[0] stays 0 throughout the bursts and rises exactly 7 edges after the final rise. Exactly one pulse occurs.
- Simultaneous plus independent: from 8'h25, drive 8'hDA (all bits flip) on one edge. Required: a single update to 8'hDA and o_chg_mask=8'hFF for exactly 1 cycle.
- Reset mid-count: start a change to 8'h80, then assert t_rst 3 cycles later. Required: o_sw=8'h00 and all counters are 0 immediately. After release with the input still 8'h80, the full 7-edge latency applies again.
- IRQ (SW_DEBOUNCE_IRQ_EN defined): after a change, o_sw_irq=1 and stays 1 until t_irq_ack. Asserting t_irq_ack on the same edge as a new o_chg pulse leaves o_sw_irq=1. With the macro undefined, o_sw_irq stays 0 across all scenarios.
